fir_cfg_ctrl: RTL and testbench

FIR_CFG_CTRL -- requirements
Module: fir_cfg_ctrl

---
 rtl/fir_cfg_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_fir_cfg_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_cfg_ctrl.sv
// fir_cfg_ctrl -- coefficient reconfiguration controller for a streaming FIR.
//
// Samples pass from the upstream port to the FIR input register. Coefficients
// are written into a shadow bank at any time. A commit request drains the
// FIR (stops accepting samples and waits for every in-flight sample to come
// out). It then copies the shadow bank to the active bank in one LOAD cycle.
// Next it injects NTAP-1 zero samples to flush the old history out of the
// delay line. The FIR outputs caused by the flush samples are withheld from
// the sink.
//
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   S_VALID/S_DATA      upstream sample, accepted when S_READY is high
//   S_READY             high in RUN only, low while RST is asserted
//   CFG_WE/ADDR/DATA    shadow coefficient write (index 0..4, 5..7 ignored)
//   CFG_COMMIT          request to apply the shadow bank
//   CFG_BUSY            commit pending, sequence running, or drops owed
//   FIR_VIN/FIR_DIN     registered FIR input valid / sample
//   FIR_B0..FIR_B4      active coefficients
//   FIR_VOUT            FIR output valid
//   VOUT                FIR_VOUT qualified by the flush-drop counter
//   ERR                 sticky in-flight counter under/overflow
module fir_cfg_ctrl #(
    parameter int NB   = 9,
    parameter int NTAP = 5,
    parameter int CW   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 S_VALID,
    input  logic signed [NB-1:0] S_DATA,
    output logic                 S_READY,
    input  logic                 CFG_WE,
    input  logic [2:0]           CFG_ADDR,
    input  logic signed [NB-1:0] CFG_DATA,
    input  logic                 CFG_COMMIT,
    output logic                 CFG_BUSY,
    output logic                 FIR_VIN,
    output logic signed [NB-1:0] FIR_DIN,
    output logic signed [NB-1:0] FIR_B0,
    output logic signed [NB-1:0] FIR_B1,
    output logic signed [NB-1:0] FIR_B2,
    output logic signed [NB-1:0] FIR_B3,
    output logic signed [NB-1:0] FIR_B4,
    input  logic                 FIR_VOUT,
    output logic                 VOUT,
    output logic                 ERR
);

    localparam int NCOEF = 5;
    localparam int FW    = $clog2(NTAP) + 1;
    // Index of the final flush cycle (NTAP-1 cycles, counted from 0).
    localparam logic [FW-1:0] FLUSH_LAST = FW'(NTAP - 2);

    typedef enum logic [1:0] {RUN, DRAIN, LOAD, FLUSH} state_t;

    state_t                state_q, state_d;
    logic                  pending_q, pending_d;
    logic [FW-1:0]         fcnt_q, fcnt_d;
    logic [CW-1:0]         infl_q, infl_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic                  err_q, err_d;
    logic                  vin_q, vin_d;
    logic signed [NB-1:0]  din_q, din_d;
    logic signed [NB-1:0]  shadow_q [NCOEF];
    logic signed [NB-1:0]  shadow_d [NCOEF];
    logic signed [NB-1:0]  coef_q   [NCOEF];
    logic signed [NB-1:0]  coef_d   [NCOEF];
    logic                  flush_inj;
    logic                  drop_dec;
    logic                  infl_err;

    // Up/down counter step. It saturates at both ends, and a simultaneous
    // increment and decrement cancel out.
    function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] c,
                                               input logic inc,
                                               input logic dec);
        logic [CW-1:0] r;
        r = c;
        if (inc && !dec && (c != {CW{1'b1}})) r = c + 1'b1;
        if (dec && !inc && (c != '0))         r = c - 1'b1;
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        fcnt_d    = fcnt_q;
        vin_d     = 1'b0;
        din_d     = din_q;
        shadow_d  = shadow_q;
        coef_d    = coef_q;
        flush_inj = 1'b0;

        case (state_q)
            RUN: begin
                if (S_VALID) begin
                    vin_d = 1'b1;
                    din_d = S_DATA;
                end
                // A pending commit from a previous sequence collapses with a
                // fresh one into a single drain/load/flush.
                if (CFG_COMMIT || pending_q) begin
                    state_d   = DRAIN;
                    pending_d = 1'b0;
                end
            end
            DRAIN: begin
                // vin_q is checked too because the sample accepted in the
                // commit cycle is not yet counted as in flight.
                if ((infl_q == '0) && !vin_q) state_d = LOAD;
            end
            LOAD: begin
                coef_d  = shadow_q;
                fcnt_d  = '0;
                state_d = FLUSH;
            end
            FLUSH: begin
                vin_d     = 1'b1;
                din_d     = '0;
                flush_inj = 1'b1;
                if (fcnt_q == FLUSH_LAST) begin
                    fcnt_d  = '0;
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if (CFG_COMMIT && (state_q != RUN)) pending_d = 1'b1;

        if (CFG_WE && (CFG_ADDR < 3'd5)) shadow_d[CFG_ADDR] = CFG_DATA;

        // Underflow: an output arrives with nothing in flight. Overflow: an
        // increment arrives when the counter is already at its maximum.
        infl_err = (FIR_VOUT && !vin_q && (infl_q == '0)) ||
                   (vin_q && !FIR_VOUT && (infl_q == {CW{1'b1}}));
        infl_d   = cnt_step(infl_q, vin_q, FIR_VOUT);
        err_d    = err_q | infl_err;

        drop_dec = FIR_VOUT && (drop_q != '0);
        drop_d   = cnt_step(drop_q, flush_inj, drop_dec);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= RUN;
            pending_q <= 1'b0;
            fcnt_q    <= '0;
            infl_q    <= '0;
            drop_q    <= '0;
            err_q     <= 1'b0;
            vin_q     <= 1'b0;
            din_q     <= '0;
            for (int i = 0; i < NCOEF; i++) begin
                shadow_q[i] <= '0;
                coef_q[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            fcnt_q    <= fcnt_d;
            infl_q    <= infl_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
            vin_q     <= vin_d;
            din_q     <= din_d;
            shadow_q  <= shadow_d;
            coef_q    <= coef_d;
        end
    end

    // Combinational outputs are gated by RST so that they read 0 from the
    // first reset cycle, before the registers have been cleared.
    assign S_READY  = (state_q == RUN) && !RST;
    assign CFG_BUSY = !RST && ((state_q != RUN) || pending_q || (drop_q != '0));
    assign VOUT     = !RST && FIR_VOUT && (drop_q == '0);
    assign FIR_VIN  = vin_q;
    assign FIR_DIN  = din_q;
    assign FIR_B0   = coef_q[0];
    assign FIR_B1   = coef_q[1];
    assign FIR_B2   = coef_q[2];
    assign FIR_B3   = coef_q[3];
    assign FIR_B4   = coef_q[4];
    assign ERR      = err_q;

endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// Directed testbench for fir_cfg_ctrl. A two-cycle FIR valid pipeline model
// drives FIR_VOUT, and a spurious-output override can be added to it.
module tb_fir_cfg_ctrl;

    localparam int NB = 9;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 S_VALID;
    logic signed [NB-1:0] S_DATA;
    logic                 S_READY;
    logic                 CFG_WE;
    logic [2:0]           CFG_ADDR;
    logic signed [NB-1:0] CFG_DATA;
    logic                 CFG_COMMIT;
    logic                 CFG_BUSY;
    logic                 FIR_VIN;
    logic signed [NB-1:0] FIR_DIN;
    logic signed [NB-1:0] FIR_B0, FIR_B1, FIR_B2, FIR_B3, FIR_B4;
    logic                 FIR_VOUT;
    logic                 VOUT;
    logic                 ERR;

    logic [1:0] vp;
    logic       spur;

    int total = 0;
    int fails = 0;

    fir_cfg_ctrl #(.NB(NB), .NTAP(5), .CW(4)) dut (
        .CLK(CLK), .RST(RST),
        .S_VALID(S_VALID), .S_DATA(S_DATA), .S_READY(S_READY),
        .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
        .CFG_COMMIT(CFG_COMMIT), .CFG_BUSY(CFG_BUSY),
        .FIR_VIN(FIR_VIN), .FIR_DIN(FIR_DIN),
        .FIR_B0(FIR_B0), .FIR_B1(FIR_B1), .FIR_B2(FIR_B2),
        .FIR_B3(FIR_B3), .FIR_B4(FIR_B4),
        .FIR_VOUT(FIR_VOUT), .VOUT(VOUT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // FIR model: output valid two cycles after input valid.
    always @(posedge CLK) begin
        if (RST) vp <= 2'b00;
        else     vp <= {vp[0], FIR_VIN};
    end
    assign FIR_VOUT = vp[1] | spur;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_coefs(input string tag, input int e0, input int e1,
                             input int e2, input int e3, input int e4);
        chk({tag, "_b0"}, 32'(FIR_B0), 32'(e0));
        chk({tag, "_b1"}, 32'(FIR_B1), 32'(e1));
        chk({tag, "_b2"}, 32'(FIR_B2), 32'(e2));
        chk({tag, "_b3"}, 32'(FIR_B3), 32'(e3));
        chk({tag, "_b4"}, 32'(FIR_B4), 32'(e4));
    endtask

    initial begin
        RST = 1'b1; S_VALID = 1'b0; S_DATA = '0; CFG_WE = 1'b0; CFG_ADDR = '0;
        CFG_DATA = '0; CFG_COMMIT = 1'b0; spur = 1'b0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_s_ready", S_READY, 0);
            chk("rst_fir_vin", FIR_VIN, 0);
            chk("rst_cfg_busy", CFG_BUSY, 0);
            chk("rst_vout", VOUT, 0);
        end
        chk("rst_fir_din", 32'(FIR_DIN), 0);
        chk("rst_err", ERR, 0);
        chk_coefs("rst", 0, 0, 0, 0, 0);
        RST = 1'b0;
        #1;
        chk("post_rst_s_ready", S_READY, 1);
        tick();
        chk("post_rst_s_ready_next", S_READY, 1);

        // Stream 1..10.
        for (int i = 1; i <= 10; i++) begin
            S_VALID = 1'b1;
            S_DATA  = NB'(i);
            chk("stream_s_ready", S_READY, 1);
            tick();
            chk("stream_vin", FIR_VIN, 1);
            chk("stream_din", 32'(FIR_DIN), 32'(i));
        end
        S_VALID = 1'b0;
        tick();
        chk("stream_vin_idle", FIR_VIN, 0);
        chk("stream_din_hold", 32'(FIR_DIN), 10);
        tick(); tick(); tick();
        chk("stream_err", ERR, 0);
        chk("stream_busy", CFG_BUSY, 0);

        // Shadow writes, plus one to an ignored address.
        for (int i = 0; i < 5; i++) begin
            CFG_WE = 1'b1; CFG_ADDR = 3'(i); CFG_DATA = NB'(i + 1);
            tick();
        end
        CFG_ADDR = 3'd6; CFG_DATA = NB'(99);
        tick();
        CFG_WE = 1'b0;
        chk_coefs("shadow_only", 0, 0, 0, 0, 0);
        chk("addr6_no_err", ERR, 0);

        // Commit with two samples in flight.
        S_VALID = 1'b1; S_DATA = NB'(11);
        tick();
        chk("c_vin_a", FIR_VIN, 1);
        chk("c_din_a", 32'(FIR_DIN), 11);
        S_DATA = NB'(12); CFG_COMMIT = 1'b1;
        chk("c_ready_commit_cycle", S_READY, 1);
        tick();
        S_VALID = 1'b0; CFG_COMMIT = 1'b0;
        chk("c_vin_b", FIR_VIN, 1);
        chk("c_din_b", 32'(FIR_DIN), 12);
        chk("c_ready_drain", S_READY, 0);
        chk("c_busy_drain", CFG_BUSY, 1);
        tick();
        chk("c_vin_drain", FIR_VIN, 0);
        chk("c_vout_a", VOUT, 1);
        chk("c_b0_drain1", 32'(FIR_B0), 0);
        tick();
        chk("c_vout_b", VOUT, 1);
        chk("c_b0_drain2", 32'(FIR_B0), 0);
        tick();
        chk("c_vout_none", VOUT, 0);
        chk("c_ready_drain3", S_READY, 0);
        tick();
        chk("c_b0_at_load", 32'(FIR_B0), 0);
        tick();
        chk_coefs("c_loaded", 1, 2, 3, 4, 5);
        chk("c_vin_after_load", FIR_VIN, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("c_flush_vin", FIR_VIN, 1);
            chk("c_flush_din", 32'(FIR_DIN), 0);
            chk("c_flush_ready", S_READY, (k == 3) ? 1 : 0);
            if (k >= 2) chk("c_flush_vout_drop", VOUT, 0);
        end
        tick();
        chk("c_post_vin", FIR_VIN, 0);
        chk("c_drop_vout3", VOUT, 0);
        chk("c_busy_drop3", CFG_BUSY, 1);
        tick();
        chk("c_drop_vout4", VOUT, 0);
        chk("c_busy_drop4", CFG_BUSY, 1);
        tick();
        chk("c_busy_clear", CFG_BUSY, 0);
        chk("c_ready_run", S_READY, 1);
        chk("c_err", ERR, 0);

        // Commit during FLUSH with a simultaneous shadow write.
        CFG_COMMIT = 1'b1;
        tick();
        CFG_COMMIT = 1'b0;
        tick();
        tick();
        CFG_COMMIT = 1'b1; CFG_WE = 1'b1; CFG_ADDR = 3'd2; CFG_DATA = NB'(7);
        tick();
        CFG_COMMIT = 1'b0; CFG_WE = 1'b0;
        chk("f_busy", CFG_BUSY, 1);
        chk("f_b2_unchanged", 32'(FIR_B2), 3);
        tick(); tick(); tick();
        chk("f_ready_run_between", S_READY, 1);
        tick();
        chk("f_ready_second_drain", S_READY, 0);
        for (int n = 0; n < 40 && FIR_B2 !== NB'(7); n++) tick();
        chk_coefs("f_reload", 1, 2, 7, 4, 5);
        for (int n = 0; n < 40 && CFG_BUSY !== 1'b0; n++) tick();
        chk("f_busy_clear", CFG_BUSY, 0);
        chk("f_ready_end", S_READY, 1);
        chk("f_err", ERR, 0);

        // Spurious FIR output with nothing in flight.
        spur = 1'b1;
        #1;
        chk("s_vout_follows", VOUT, 1);
        tick();
        spur = 1'b0;
        chk("s_err_set", ERR, 1);
        tick(); tick();
        chk("s_err_sticky", ERR, 1);

        // Reset during the second FLUSH cycle.
        CFG_COMMIT = 1'b1;
        tick();
        CFG_COMMIT = 1'b0;
        for (int n = 0; n < 20 && FIR_VIN !== 1'b1; n++) tick();
        chk("r_in_flush", FIR_VIN, 1);
        chk_coefs("r_loaded", 1, 2, 7, 4, 5);
        RST = 1'b1;
        #1;
        chk("r_ready_in_rst", S_READY, 0);
        tick();
        chk_coefs("r_cleared", 0, 0, 0, 0, 0);
        chk("r_vin", FIR_VIN, 0);
        chk("r_busy", CFG_BUSY, 0);
        chk("r_err_cleared", ERR, 0);
        RST = 1'b0;
        #1;
        chk("r_ready_after", S_READY, 1);
        S_VALID = 1'b1; S_DATA = NB'(5);
        tick();
        S_VALID = 1'b0;
        chk("r_vin_sample", FIR_VIN, 1);
        chk("r_busy_after", CFG_BUSY, 0);
        tick(); tick();
        chk("r_vout_unsuppressed", VOUT, 1);
        tick();
        chk("r_err_after", ERR, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
